regfile_sb: RTL and testbench

Parametrised general-purpose register file with an integrated write-back scoreboard for the pipelined NPC core. It provides NRD combinational read ports with same-cycle write bypass, NWR write-back ports, and per-register busy tracking so the decode stage can detect RAW hazards and stall WAW hazards. It sits between IDU (issue, operand read) and WBU (write-back), and replaces the single-cycle register file.

---
 rtl/npc_pkg.sv | 11 +
 rtl/reg_scoreboard.sv | 70 +++++++
 rtl/regfile_sb.sv | 76 +++++++
 tb/tb_regfile_sb.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared NPC core definitions: default datapath sizing and the common word/address types.
package npc_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0]   reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Write-back scoreboard: one busy bit per architectural register, set on issue and
// cleared by write-back or flush. Also produces issue readiness and the busy count.
module reg_scoreboard
  import npc_pkg::*;
#(
  parameter int unsigned NREGS = npc_pkg::NREGS,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wen,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    rbusy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic              flush,
  output logic [AW:0]       busy_cnt
);

  logic [NREGS-1:0] busy_q, busy_d, wr_hit;

  // Registers receiving a real (non-x0) write-back this cycle.
  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] && waddr[j*AW +: AW] != '0) begin
        wr_hit[waddr[j*AW +: AW]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rbusy[i] = busy_q[raddr[i*AW +: AW]] & ~wr_hit[raddr[i*AW +: AW]];
    end
  end

  assign iss_ready = (iss_rd == '0) || !busy_q[iss_rd] || wr_hit[iss_rd];

  // Later assignments take priority: write clear < flush < issue set.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (flush) begin
      busy_d = '0;
    end
    if (iss_valid && iss_ready && iss_rd != '0) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_cnt = busy_cnt + {{AW{1'b0}}, busy_q[r]};
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with same-cycle write bypass; hazard tracking is
// delegated to reg_scoreboard. x0 reads as zero and ignores writes.
module regfile_sb
  import npc_pkg::*;
#(
  parameter int unsigned XLEN  = npc_pkg::XLEN,
  parameter int unsigned NREGS = npc_pkg::NREGS,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  // Kept as a plain unpacked array so the difftest harness can reference it directly.
  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && waddr[j*AW +: AW] != '0) begin
          regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rdata[i*XLEN +: XLEN] = regs[raddr[i*AW +: AW]];
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && waddr[j*AW +: AW] == raddr[i*AW +: AW]) begin
          rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
        end
      end
      if (raddr[i*AW +: AW] == '0) begin
        rdata[i*XLEN +: XLEN] = '0;
      end
    end
  end

  reg_scoreboard #(
    .NREGS(NREGS),
    .NRD  (NRD),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .waddr    (waddr),
    .raddr    (raddr),
    .rbusy    (rbusy),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .iss_ready(iss_ready),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with two read and two write-back ports.
module tb_regfile_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NWR  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic                flush;
  logic [AW:0]         busy_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_sb #(
    .XLEN (XLEN),
    .NREGS(32),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .iss_ready(iss_ready),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle inputs 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; raddr = '0; wen = '0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_busy_cnt", 64'(busy_cnt), 64'd0);
    for (int r = 0; r < 32; r++) begin
      raddr[4:0] = 5'(r);
      #1;
      chk("reset_rdata0", 64'(rdata[31:0]), 64'd0);
      chk("reset_rbusy0", 64'(rbusy[0]), 64'd0);
    end

    // Bypass then array read of x5.
    wen = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF; raddr[4:0] = 5'd5;
    #1;
    chk("bypass_x5", 64'(rdata[31:0]), 64'hDEADBEEF);
    tick();
    wen = '0;
    #1;
    chk("array_x5", 64'(rdata[31:0]), 64'hDEADBEEF);

    // x0 is hardwired.
    wen = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'h1234; raddr[4:0] = 5'd0;
    #1;
    chk("x0_bypass", 64'(rdata[31:0]), 64'd0);
    tick();
    wen = '0;
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    chk("x0_read", 64'(rdata[31:0]), 64'd0);
    chk("x0_iss_ready", 64'(iss_ready), 64'd1);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("x0_busy_cnt", 64'(busy_cnt), 64'd0);

    // RAW/WAW on x7.
    iss_valid = 1'b1; iss_rd = 5'd7; raddr[9:5] = 5'd7;
    #1;
    chk("iss7_ready_first", 64'(iss_ready), 64'd1);
    tick();
    #1;
    chk("iss7_busy_cnt", 64'(busy_cnt), 64'd1);
    chk("iss7_stall", 64'(iss_ready), 64'd0);
    chk("iss7_rbusy", 64'(rbusy[1]), 64'd1);
    tick();
    #1;
    chk("stall_no_change", 64'(busy_cnt), 64'd1);
    wen = 2'b01; waddr[4:0] = 5'd7; wdata[31:0] = 32'h55;
    #1;
    chk("wb7_iss_ready", 64'(iss_ready), 64'd1);
    chk("wb7_rbusy", 64'(rbusy[1]), 64'd0);
    chk("wb7_bypass", 64'(rdata[63:32]), 64'h55);
    tick();
    wen = '0; iss_valid = 1'b0;
    #1;
    chk("reissue7_busy_cnt", 64'(busy_cnt), 64'd1);
    chk("reissue7_rbusy", 64'(rbusy[1]), 64'd1);
    chk("reissue7_data", 64'(rdata[63:32]), 64'h55);
    wen = 2'b01; waddr[4:0] = 5'd7; wdata[31:0] = 32'h55;
    tick();
    wen = '0;
    #1;
    chk("clear7_busy_cnt", 64'(busy_cnt), 64'd0);

    // Two ports to x3: higher port wins.
    wen = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h22, 32'h11}; raddr[4:0] = 5'd3;
    #1;
    chk("dual_bypass_x3", 64'(rdata[31:0]), 64'h22);
    tick();
    wen = '0;
    #1;
    chk("dual_array_x3", 64'(rdata[31:0]), 64'h22);

    // Issue 1,2,3 then flush alongside issue of 4.
    iss_valid = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      iss_rd = 5'(r);
      tick();
    end
    iss_valid = 1'b0;
    #1;
    chk("three_busy", 64'(busy_cnt), 64'd3);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    flush = 1'b0; iss_valid = 1'b0;
    raddr = {5'd1, 5'd4};
    #1;
    chk("flush_busy_cnt", 64'(busy_cnt), 64'd1);
    chk("flush_x4_busy", 64'(rbusy[0]), 64'd1);
    chk("flush_x1_free", 64'(rbusy[1]), 64'd0);

    // Reset mid-operation drops the in-flight write to x9.
    rst = 1'b1; wen = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'hCAFE;
    tick();
    rst = 1'b0; wen = '0;
    raddr = {5'd9, 5'd3};
    #1;
    chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("rst_x3", 64'(rdata[31:0]), 64'd0);
    chk("rst_x9_dropped", 64'(rdata[63:32]), 64'd0);
    raddr = {5'd7, 5'd5};
    #1;
    chk("rst_x5", 64'(rdata[31:0]), 64'd0);
    chk("rst_x7", 64'(rdata[63:32]), 64'd0);
    chk("rst_rbusy", 64'(rbusy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
